imm_ext_fifo: RTL and testbench

Parametrised, buffered immediate extender for the multi-cycle datapath. Accepts IN_W-bit immediates with an extension opcode over a valid/ready handshake and extends them to OUT_W bits per opcode. Results are queued in a DEPTH-entry FIFO, so decode can run ahead of the ALU-source mux. Adds LUI and branch-offset modes, backpressure, flush and an illegal-op flag.

---
 rtl/ext_pkg.sv | 20 ++
 rtl/ext_core.sv | 41 ++++
 rtl/imm_ext_fifo.sv | 125 ++++++++++++
 tb/tb_imm_ext_fifo.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/ext_pkg.sv
// Shared definitions for the immediate extender: opcode width, opcode
// encodings and a legality helper used by the extension core.
package ext_pkg;

  localparam int EXTOP_W = 3;

  typedef logic [EXTOP_W-1:0] extop_t;

  localparam extop_t EXTOP_UNSIGNED = 3'd0;
  localparam extop_t EXTOP_SIGNED   = 3'd1;
  localparam extop_t EXTOP_INST     = 3'd2;
  localparam extop_t EXTOP_LUI      = 3'd3;
  localparam extop_t EXTOP_BRANCH   = 3'd4;

  // Opcodes above BRANCH are reserved and flagged as illegal.
  function automatic logic is_legal_op(input extop_t op);
    return (op <= EXTOP_BRANCH);
  endfunction

endpackage

// File: rtl/ext_core.sv
// Combinational immediate extension: maps an IN_W-bit immediate and an
// extension opcode to an OUT_W-bit value plus an illegal-opcode flag.
module ext_core
  import ext_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int BR_SHIFT = 2
) (
  input  logic [IN_W-1:0]    in_imm,
  input  logic [EXTOP_W-1:0] in_op,
  output logic [OUT_W-1:0]   ext_value,
  output logic               op_illegal
);

  logic [OUT_W-1:0] zext_s;
  logic [OUT_W-1:0] sext_s;

  // Build zero- and sign-extended forms without zero-width replications,
  // so OUT_W == IN_W remains a legal configuration.
  always_comb begin
    zext_s             = OUT_W'(in_imm);
    sext_s             = {OUT_W{in_imm[IN_W-1]}};
    sext_s[IN_W-1:0]   = in_imm;
  end

  // Select the extension form by opcode; reserved opcodes zero-extend.
  always_comb begin
    ext_value  = '0;
    op_illegal = !is_legal_op(in_op);
    case (in_op)
      EXTOP_UNSIGNED: ext_value = zext_s;
      EXTOP_SIGNED:   ext_value = sext_s;
      EXTOP_INST:     ext_value = '0;
      EXTOP_LUI:      ext_value = zext_s << (OUT_W - IN_W);
      EXTOP_BRANCH:   ext_value = sext_s << BR_SHIFT;
      default:        ext_value = zext_s;
    endcase
  end

endmodule

// File: rtl/imm_ext_fifo.sv
// Buffered immediate extender. Extension happens at the input; a DEPTH-entry
// FIFO of OUT_W-bit results decouples decode from the ALU-source mux.
// Optional macro EXT_TRACE_EN adds simulation-only push/flush trace output.
module imm_ext_fifo
  import ext_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int BR_SHIFT = 2,
  parameter int DEPTH    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IN_W-1:0]          in_imm,
  input  logic [EXTOP_W-1:0]       in_op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_imm,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     illegal
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [OUT_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             illegal_r;

  logic [OUT_W-1:0] ext_value_s;
  logic             op_illegal_s;
  logic             push_s;
  logic             pop_s;

  ext_core #(
    .IN_W     (IN_W),
    .OUT_W    (OUT_W),
    .BR_SHIFT (BR_SHIFT)
  ) u_core (
    .in_imm     (in_imm),
    .in_op      (in_op),
    .ext_value  (ext_value_s),
    .op_illegal (op_illegal_s)
  );

  // Handshake qualifiers and head-entry presentation; all outputs come from
  // registered state, so a full FIFO stays closed even during a pop.
  always_comb begin
    in_ready  = (count_r != CW'(DEPTH));
    out_valid = (count_r != {CW{1'b0}});
    push_s    = in_valid & in_ready;
    pop_s     = out_valid & out_ready;
    count     = count_r;
    illegal   = illegal_r;
    if (out_valid) begin
      out_imm = mem_r[rd_ptr_r];
    end else begin
      out_imm = '0;
    end
  end

  // Pointer, occupancy and sticky-flag state; flush beats push and pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      count_r   <= '0;
      illegal_r <= 1'b0;
    end else begin
      if (push_s && op_illegal_s) begin
        illegal_r <= 1'b1;
      end else begin
        illegal_r <= illegal_r;
      end
      if (flush) begin
        wr_ptr_r <= '0;
        rd_ptr_r <= '0;
        count_r  <= '0;
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + AW'(1);
        end else begin
          wr_ptr_r <= wr_ptr_r;
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + AW'(1);
        end else begin
          rd_ptr_r <= rd_ptr_r;
        end
        case ({push_s, pop_s})
          2'b10:   count_r <= count_r + CW'(1);
          2'b01:   count_r <= count_r - CW'(1);
          default: count_r <= count_r;
        endcase
      end
    end
  end

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_s && !flush) begin
      mem_r[wr_ptr_r] <= ext_value_s;
    end
  end

`ifdef EXT_TRACE_EN
  // Simulation trace of accepted immediates and flushes that drop entries.
  always_ff @(posedge clk) begin
    if (rst && push_s) begin
      $display("EXT in: %x, op: %d, out: %x", in_imm, in_op, ext_value_s);
    end
    if (rst && flush && (count_r != {CW{1'b0}})) begin
      $display("EXT flush: %d dropped", count_r);
    end
  end
`else
  // Trace output disabled; behaviour is otherwise identical.
`endif

endmodule

// File: tb/tb_imm_ext_fifo.sv
// Directed testbench for imm_ext_fifo with a queue-based scoreboard.
module tb_imm_ext_fifo;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [2:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic [1:0]  count;
  logic        illegal;

  int checks;
  int failures;
  logic [31:0] sb_q[$];
  logic        illegal_exp;

  imm_ext_fifo #(
    .IN_W (16), .OUT_W (32), .BR_SHIFT (2), .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_imm   (out_imm),
    .count     (count),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check visible state against the scoreboard, apply one cycle of stimulus,
  // then advance the model to match what the DUT should do on the edge.
  task automatic step(input string tag, input logic v, input logic [15:0] imm,
                      input logic [2:0] op, input logic ordy, input logic fl,
                      input logic [31:0] exp);
    logic accept;
    logic take;
    in_valid  = v;
    in_imm    = imm;
    in_op     = op;
    out_ready = ordy;
    flush     = fl;
    chk({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, (sb_q.size() < DEPTH)});
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, (sb_q.size() != 0)});
    chk({tag, ".out_imm"},   out_imm, (sb_q.size() != 0) ? sb_q[0] : 32'd0);
    chk({tag, ".count"},     {30'd0, count},     sb_q.size());
    chk({tag, ".illegal"},   {31'd0, illegal},   {31'd0, illegal_exp});
    accept = v && (sb_q.size() < DEPTH);
    take   = ordy && (sb_q.size() != 0);
    if (accept && (op > 3'd4)) illegal_exp = 1'b1;
    if (fl) begin
      sb_q.delete();
    end else begin
      if (take) void'(sb_q.pop_front());
      if (accept) sb_q.push_back(exp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    illegal_exp = 1'b0;
    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_imm    = 16'h0000;
    in_op     = 3'd0;
    out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst.count", {30'd0, count}, 32'd0);
    chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.out_imm", out_imm, 32'd0);
    chk("rst.illegal", {31'd0, illegal}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // SIGNED push, visible next cycle
    step("sgn",  1'b1, 16'h8001, 3'd1, 1'b1, 1'b0, 32'hFFFF8001);
    step("sgn2", 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0, 32'h0);
    step("empty_pop", 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0, 32'h0);

    // LUI, BRANCH, UNSIGNED streamed with concurrent push/pop
    step("lui",  1'b1, 16'h1234, 3'd3, 1'b1, 1'b0, 32'h12340000);
    step("br",   1'b1, 16'hFFFF, 3'd4, 1'b1, 1'b0, 32'hFFFFFFFC);
    step("uns",  1'b1, 16'h8001, 3'd0, 1'b1, 1'b0, 32'h00008001);
    step("inst", 1'b1, 16'hFFFF, 3'd2, 1'b1, 1'b0, 32'h00000000);
    step("drn1", 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0, 32'h0);
    step("drn2", 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0, 32'h0);

    // Backpressure and full: third push held until space opens
    step("f1",   1'b1, 16'h0001, 3'd0, 1'b0, 1'b0, 32'h1);
    step("f2",   1'b1, 16'h0002, 3'd0, 1'b0, 1'b0, 32'h2);
    step("f3a",  1'b1, 16'h0003, 3'd0, 1'b0, 1'b0, 32'h3);
    step("f3b",  1'b1, 16'h0003, 3'd0, 1'b1, 1'b0, 32'h3);
    step("f3c",  1'b1, 16'h0003, 3'd0, 1'b1, 1'b0, 32'h3);
    step("f4",   1'b0, 16'h0000, 3'd0, 1'b1, 1'b0, 32'h0);
    step("f5",   1'b0, 16'h0000, 3'd0, 1'b1, 1'b0, 32'h0);

    // Flush with a full FIFO and a concurrent push attempt
    step("fl1",  1'b1, 16'h0011, 3'd0, 1'b0, 1'b0, 32'h11);
    step("fl2",  1'b1, 16'h0022, 3'd0, 1'b0, 1'b0, 32'h22);
    step("fl3",  1'b1, 16'h0033, 3'd0, 1'b1, 1'b1, 32'h33);
    step("fl4",  1'b0, 16'h0000, 3'd0, 1'b1, 1'b0, 32'h0);
    step("fl5",  1'b0, 16'h0000, 3'd0, 1'b1, 1'b0, 32'h0);

    // Illegal opcode: zero-extends, sticky through flush
    step("ill1", 1'b1, 16'hABCD, 3'd6, 1'b0, 1'b0, 32'h0000ABCD);
    step("ill2", 1'b0, 16'h0000, 3'd0, 1'b0, 1'b1, 32'h0);
    step("ill3", 1'b0, 16'h0000, 3'd0, 1'b1, 1'b0, 32'h0);

    // Asynchronous reset mid-stream with one entry queued
    step("mr1",  1'b1, 16'h5555, 3'd0, 1'b0, 1'b0, 32'h5555);
    in_valid = 1'b0;
    chk("mr.count_pre", {30'd0, count}, 32'd1);
    rst = 1'b0;
    #1;
    chk("mr.count", {30'd0, count}, 32'd0);
    chk("mr.out_valid", {31'd0, out_valid}, 32'd0);
    chk("mr.in_ready", {31'd0, in_ready}, 32'd1);
    chk("mr.out_imm", out_imm, 32'd0);
    chk("mr.illegal", {31'd0, illegal}, 32'd0);
    sb_q.delete();
    illegal_exp = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    step("mr2",  1'b1, 16'h7FFF, 3'd1, 1'b1, 1'b0, 32'h00007FFF);
    step("mr3",  1'b0, 16'h0000, 3'd0, 1'b1, 1'b0, 32'h0);
    step("mr4",  1'b0, 16'h0000, 3'd0, 1'b1, 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
